branch_seq_unit: RTL and testbench
==================================

# branch_seq_unit

Multi-cycle branch sequencer for the reference MIPS core. It replaces the purely combinational branch step with a registered unit that evaluates the condition and target when a branch is issued, then holds the branch for a configurable number of delay-slot commits. After those commits it emits a single resolve pulse with the redirect PC and link data. The branch counts as committed only on that pulse.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC/target width; legal range 28..32.
- DELAY_SLOTS, 1, committed instructions between branch and redirect; legal range 0..3.

Ports:
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous active-high reset.
- issue_valid  in  1  branch offered.
- issue_ready  out  1  unit can accept; high only in S_IDLE.
- issue_op  in  4  branch_op_t: BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL, J, JAL, JR, JALR, BEQL, BNEL, BLEZL, BGTZL.
- issue_pc  in  ADDR_WIDTH  PC of the branch.
- issue_rs, issue_rt  in  32  operand values.
- issue_imm  in  26  instr_index; bits [15:0] are the branch offset.
- slot_commit  in  1  one delay-slot instruction committed this cycle.
- flush  in  1  exception/ERET flush; abandons the pending branch.
- slot_nullify  out  1  current delay slot must not write state.
- resolve_valid  out  1  one-cycle pulse: branch complete.
- resolve_taken  out  1  condition result.
- resolve_pc  out  ADDR_WIDTH  next fetch PC.
- resolve_addr_err  out  1  taken target has target[1:0] != 0.
- link_we  out  1  write link register (qualified by resolve_valid).
- link_data  out  32  issue_pc + 4*(DELAY_SLOTS+1), zero-extended.

## Operation
- States: S_IDLE, S_SLOT, S_RESOLVE.
- Handshake: accept when issue_valid && issue_ready. At accept, register taken, target, link data, link_we, likely flag and slot counter = DELAY_SLOTS.
  - DELAY_SLOTS == 0: go to S_RESOLVE.
  - Otherwise: go to S_SLOT.
- Conditions are signed 32-bit compares on rs (and rt). J, JAL, JR and JALR are always taken.
- Branch target: pc + 4 + (sext(imm[15:0]) << 2).
- J/JAL target: {(pc+4)[ADDR_WIDTH-1:28], imm, 2'b00}.
- JR/JALR target: rs[ADDR_WIDTH-1:0].
- Address arithmetic is modulo 2^ADDR_WIDTH.
- Fall-through PC: pc + 4*(DELAY_SLOTS+1). resolve_pc = taken ? target : fall-through.
- link_we is set for BLTZAL, BGEZAL, JAL and JALR, whether or not the branch is taken.
- S_SLOT: each slot_commit decrements the counter. The commit that makes it 0 moves to S_RESOLVE.
- S_RESOLVE: resolve_valid = 1 for exactly one cycle, then S_IDLE.
- resolve_addr_err is asserted only if taken.
- flush in any state: next state S_IDLE, no resolve pulse, counter cleared. flush has priority over issue and over slot_commit in the same cycle.
- slot_commit in S_IDLE or S_RESOLVE is ignored.
- Reset: state S_IDLE. All outputs 0, except issue_ready = 1 in the cycle after reset deasserts.

## Timing
- Accept at edge N.
  - DELAY_SLOTS == 0: resolve_valid at cycle N+1.
  - Otherwise: resolve_valid is high the cycle after the final slot_commit edge.
- issue_ready is low from the accept edge until the edge that leaves S_RESOLVE. A new branch can be accepted in the cycle after resolve_valid.
- Every output is a direct decode of registered state. No input-to-output combinational path.

## Configuration
- BRANCH_LIKELY_EN defined:
  - BEQL, BNEL, BLEZL and BGTZL set the likely flag.
  - slot_nullify = 1 while in S_SLOT with likely && !taken.
  - Nullified slots still count toward DELAY_SLOTS.
- BRANCH_LIKELY_EN undefined:
  - Likely ops are evaluated as their non-likely counterparts.
  - slot_nullify is tied to 0.

## Structure
- Shared package holds:
  - branch_op_t enum (4-bit);
  - branch_state_t (S_IDLE, S_SLOT, S_RESOLVE);
  - BRANCH_LINK_REG = 31.
- One sub-module, branch_cond_eval: combinational op/rs/rt → taken and link flag. The condition logic lives there; the parent owns the FSM, target arithmetic and registers.

## Test plan
- DELAY_SLOTS=1, BEQ at pc 0x00400000, rs=rt=5, imm=0x0004, one slot_commit → one resolve_valid pulse, taken=1, resolve_pc=0x00400014.
- BNE with rs=rt, DELAY_SLOTS=2, two commits spaced 3 cycles apart → resolve_pc=pc+12, taken=0, no pulse before the second commit.
- JALR with rs=0x00400102 → taken=1, resolve_addr_err=1, link_we=1, link_data=pc+8.
- flush asserted in S_SLOT in the same cycle as slot_commit → no resolve_valid, issue_ready=1 next cycle.
- With BRANCH_LIKELY_EN: BEQL, rs=1, rt=2 → slot_nullify=1 during the slot, resolve_pc=pc+8. Without the macro: slot_nullify stays 0.
- reset asserted mid-S_SLOT → the next cycle has resolve_valid=0, issue_ready=1, and all outputs 0.

Source files
------------

// File: rtl/branch_seq_unit_pkg.sv
// rtl/branch_seq_unit_pkg.sv - shared types and constants for the branch sequencer
package branch_seq_unit_pkg;

    typedef enum logic [3:0] {
        OP_BEQ    = 4'd0,
        OP_BNE    = 4'd1,
        OP_BLEZ   = 4'd2,
        OP_BGTZ   = 4'd3,
        OP_BLTZ   = 4'd4,
        OP_BGEZ   = 4'd5,
        OP_BLTZAL = 4'd6,
        OP_BGEZAL = 4'd7,
        OP_J      = 4'd8,
        OP_JAL    = 4'd9,
        OP_JR     = 4'd10,
        OP_JALR   = 4'd11,
        OP_BEQL   = 4'd12,
        OP_BNEL   = 4'd13,
        OP_BLEZL  = 4'd14,
        OP_BGTZL  = 4'd15
    } branch_op_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SLOT    = 2'd1,
        S_RESOLVE = 2'd2
    } branch_state_t;

    localparam int BRANCH_LINK_REG = 31;

endpackage

// File: rtl/branch_seq_unit_if.sv
// rtl/branch_seq_unit_if.sv - issue/slot/resolve bundle between pipeline and branch sequencer
interface branch_seq_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    import branch_seq_unit_pkg::*;

    logic                  issue_valid;
    logic                  issue_ready;
    branch_op_t            issue_op;
    logic [ADDR_WIDTH-1:0] issue_pc;
    logic [31:0]           issue_rs;
    logic [31:0]           issue_rt;
    logic [25:0]           issue_imm;
    logic                  slot_commit;
    logic                  flush;
    logic                  slot_nullify;
    logic                  resolve_valid;
    logic                  resolve_taken;
    logic [ADDR_WIDTH-1:0] resolve_pc;
    logic                  resolve_addr_err;
    logic                  link_we;
    logic [31:0]           link_data;

    modport master (
        output issue_valid, issue_op, issue_pc, issue_rs, issue_rt, issue_imm,
               slot_commit, flush,
        input  issue_ready, slot_nullify, resolve_valid, resolve_taken,
               resolve_pc, resolve_addr_err, link_we, link_data
    );

    modport slave (
        input  issue_valid, issue_op, issue_pc, issue_rs, issue_rt, issue_imm,
               slot_commit, flush,
        output issue_ready, slot_nullify, resolve_valid, resolve_taken,
               resolve_pc, resolve_addr_err, link_we, link_data
    );

endinterface

// File: rtl/branch_seq_unit_cond_eval.sv
// rtl/branch_seq_unit_cond_eval.sv - combinational branch condition and link decode
module branch_cond_eval
    import branch_seq_unit_pkg::*;
(
    input  branch_op_t  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        taken,
    output logic        link
);
    logic signed [31:0] rs_s;

    assign rs_s = rs;

    // Likely variants share the compare of their base op; nullification is decided upstream.
    always_comb begin
        taken = 1'b0;
        link  = 1'b0;
        case (op)
            OP_BEQ, OP_BEQL:   taken = (rs == rt);
            OP_BNE, OP_BNEL:   taken = (rs != rt);
            OP_BLEZ, OP_BLEZL: taken = (rs_s <= 32'sd0);
            OP_BGTZ, OP_BGTZL: taken = (rs_s >  32'sd0);
            OP_BLTZ:           taken = (rs_s <  32'sd0);
            OP_BGEZ:           taken = (rs_s >= 32'sd0);
            OP_BLTZAL: begin
                taken = (rs_s < 32'sd0);
                link  = 1'b1;
            end
            OP_BGEZAL: begin
                taken = (rs_s >= 32'sd0);
                link  = 1'b1;
            end
            OP_J, OP_JR:       taken = 1'b1;
            OP_JAL, OP_JALR: begin
                taken = 1'b1;
                link  = 1'b1;
            end
            default: begin
                taken = 1'b0;
                link  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/branch_seq_unit.sv
// rtl/branch_seq_unit.sv - registered multi-cycle branch sequencer; BRANCH_LIKELY_EN enables likely-branch slot nullification
module branch_seq_unit
    import branch_seq_unit_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DELAY_SLOTS = 1
) (
    input  logic                clk,
    input  logic                reset,
    branch_seq_unit_if.slave    bus
);
    localparam logic [ADDR_WIDTH-1:0] LOW28   = ADDR_WIDTH'(32'h0FFF_FFFF);
    localparam logic [ADDR_WIDTH-1:0] FT_OFFS = ADDR_WIDTH'(4 * (DELAY_SLOTS + 1));
    localparam logic [1:0]            SLOTS   = 2'(DELAY_SLOTS);

    branch_state_t         state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  taken_q, taken_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  addr_err_q, addr_err_d;
    logic                  link_we_q, link_we_d;
    logic [31:0]           link_data_q, link_data_d;
    logic                  likely_q, likely_d;

    logic                  c_taken, c_link, c_likely;
    logic [ADDR_WIDTH-1:0] pc_plus4, br_tgt, j_tgt, tgt, fall_pc;

    branch_cond_eval u_cond (
        .op    (bus.issue_op),
        .rs    (bus.issue_rs),
        .rt    (bus.issue_rt),
        .taken (c_taken),
        .link  (c_link)
    );

`ifdef BRANCH_LIKELY_EN
    assign c_likely = (bus.issue_op == OP_BEQL) || (bus.issue_op == OP_BNEL) ||
                      (bus.issue_op == OP_BLEZL) || (bus.issue_op == OP_BGTZL);
`else
    assign c_likely = 1'b0;
`endif

    assign pc_plus4 = bus.issue_pc + ADDR_WIDTH'(4);
    assign br_tgt   = pc_plus4 + {{(ADDR_WIDTH-18){bus.issue_imm[15]}}, bus.issue_imm[15:0], 2'b00};
    // Masking keeps the region bits correct even at the narrowest ADDR_WIDTH of 28.
    assign j_tgt    = (pc_plus4 & ~LOW28) | ADDR_WIDTH'({bus.issue_imm, 2'b00});
    assign fall_pc  = bus.issue_pc + FT_OFFS;

    always_comb begin
        case (bus.issue_op)
            OP_J, OP_JAL:   tgt = j_tgt;
            OP_JR, OP_JALR: tgt = bus.issue_rs[ADDR_WIDTH-1:0];
            default:        tgt = br_tgt;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        taken_d     = taken_q;
        pc_d        = pc_q;
        addr_err_d  = addr_err_q;
        link_we_d   = link_we_q;
        link_data_d = link_data_q;
        likely_d    = likely_q;
        if (bus.flush) begin
            state_d = S_IDLE;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.issue_valid) begin
                        taken_d     = c_taken;
                        pc_d        = c_taken ? tgt : fall_pc;
                        addr_err_d  = c_taken && (tgt[1:0] != 2'b00);
                        link_we_d   = c_link;
                        link_data_d = 32'(fall_pc);
                        likely_d    = c_likely;
                        cnt_d       = SLOTS;
                        state_d     = (DELAY_SLOTS == 0) ? S_RESOLVE : S_SLOT;
                    end
                end
                S_SLOT: begin
                    if (bus.slot_commit) begin
                        cnt_d = cnt_q - 2'd1;
                        if (cnt_q == 2'd1) state_d = S_RESOLVE;
                    end
                end
                S_RESOLVE: state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            taken_q     <= 1'b0;
            pc_q        <= '0;
            addr_err_q  <= 1'b0;
            link_we_q   <= 1'b0;
            link_data_q <= 32'd0;
            likely_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            taken_q     <= taken_d;
            pc_q        <= pc_d;
            addr_err_q  <= addr_err_d;
            link_we_q   <= link_we_d;
            link_data_q <= link_data_d;
            likely_q    <= likely_d;
        end
    end

    // Result fields are gated to the resolve cycle so they read as zero at all other times.
    assign bus.issue_ready      = (state_q == S_IDLE);
    assign bus.resolve_valid    = (state_q == S_RESOLVE);
    assign bus.resolve_taken    = bus.resolve_valid & taken_q;
    assign bus.resolve_pc       = bus.resolve_valid ? pc_q : '0;
    assign bus.resolve_addr_err = bus.resolve_valid & addr_err_q;
    assign bus.link_we          = bus.resolve_valid & link_we_q;
    assign bus.link_data        = bus.resolve_valid ? link_data_q : 32'd0;
    assign bus.slot_nullify     = (state_q == S_SLOT) && likely_q && !taken_q;

endmodule

// File: tb/tb_branch_seq_unit.sv
// tb/tb_branch_seq_unit.sv - scoreboard bench running DELAY_SLOTS 0/1/2 sequencers on shared stimulus
module tb_branch_seq_unit;
    import branch_seq_unit_pkg::*;

    typedef struct packed {
        logic        taken;
        logic [31:0] pc;
        logic        err;
        logic        lw;
        logic [31:0] ld;
    } res_t;

`ifdef BRANCH_LIKELY_EN
    localparam logic LIKELY = 1'b1;
`else
    localparam logic LIKELY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0, slot_commit = 1'b0, flush = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] pc = 32'd0, rs = 32'd0, rt = 32'd0;
    logic [25:0] imm = 26'd0;
    res_t        q0[$], q1[$], q2[$];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    branch_seq_unit_if #(.ADDR_WIDTH(32)) if0 ();
    branch_seq_unit_if #(.ADDR_WIDTH(32)) if1 ();
    branch_seq_unit_if #(.ADDR_WIDTH(32)) if2 ();

    assign if0.issue_valid = issue_valid;  assign if1.issue_valid = issue_valid;  assign if2.issue_valid = issue_valid;
    assign if0.issue_op = branch_op_t'(op); assign if1.issue_op = branch_op_t'(op); assign if2.issue_op = branch_op_t'(op);
    assign if0.issue_pc = pc;               assign if1.issue_pc = pc;               assign if2.issue_pc = pc;
    assign if0.issue_rs = rs;               assign if1.issue_rs = rs;               assign if2.issue_rs = rs;
    assign if0.issue_rt = rt;               assign if1.issue_rt = rt;               assign if2.issue_rt = rt;
    assign if0.issue_imm = imm;             assign if1.issue_imm = imm;             assign if2.issue_imm = imm;
    assign if0.slot_commit = slot_commit;   assign if1.slot_commit = slot_commit;   assign if2.slot_commit = slot_commit;
    assign if0.flush = flush;               assign if1.flush = flush;               assign if2.flush = flush;

    branch_seq_unit #(.ADDR_WIDTH(32), .DELAY_SLOTS(0)) u_ds0 (.clk(clk), .reset(reset), .bus(if0));
    branch_seq_unit #(.ADDR_WIDTH(32), .DELAY_SLOTS(1)) u_ds1 (.clk(clk), .reset(reset), .bus(if1));
    branch_seq_unit #(.ADDR_WIDTH(32), .DELAY_SLOTS(2)) u_ds2 (.clk(clk), .reset(reset), .bus(if2));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_res(input string tag, input res_t obs, input res_t exp);
        check({tag, " taken"}, 64'(obs.taken), 64'(exp.taken));
        check({tag, " pc"},    64'(obs.pc),    64'(exp.pc));
        check({tag, " err"},   64'(obs.err),   64'(exp.err));
        check({tag, " lw"},    64'(obs.lw),    64'(exp.lw));
        check({tag, " ld"},    64'(obs.ld),    64'(exp.ld));
    endtask

    function automatic res_t model(input logic [3:0] o, input logic [31:0] p, a, b,
                                   input logic [25:0] im, input int ds);
        logic        t, lw;
        logic [31:0] p4, tg, ft;
        case (o)
            4'd0, 4'd12: t = (a == b);
            4'd1, 4'd13: t = (a != b);
            4'd2, 4'd14: t = ($signed(a) <= 0);
            4'd3, 4'd15: t = ($signed(a) > 0);
            4'd4, 4'd6:  t = ($signed(a) < 0);
            4'd5, 4'd7:  t = ($signed(a) >= 0);
            default:     t = 1'b1;
        endcase
        lw = (o == 4'd6) || (o == 4'd7) || (o == 4'd9) || (o == 4'd11);
        p4 = p + 32'd4;
        case (o)
            4'd8, 4'd9:   tg = {p4[31:28], im, 2'b00};
            4'd10, 4'd11: tg = a;
            default:      tg = p4 + {{14{im[15]}}, im[15:0], 2'b00};
        endcase
        ft = p + 32'(4 * (ds + 1));
        model = '{taken: t, pc: (t ? tg : ft), err: (t && (tg[1:0] != 2'b00)), lw: lw, ld: ft};
    endfunction

    always @(negedge clk) if (if0.resolve_valid === 1'b1) begin
        if (q0.size() == 0) check("ds0 unexpected resolve", 1, 0);
        else compare_res("ds0", res_t'{if0.resolve_taken, if0.resolve_pc, if0.resolve_addr_err, if0.link_we, if0.link_data}, q0.pop_front());
    end
    always @(negedge clk) if (if1.resolve_valid === 1'b1) begin
        if (q1.size() == 0) check("ds1 unexpected resolve", 1, 0);
        else compare_res("ds1", res_t'{if1.resolve_taken, if1.resolve_pc, if1.resolve_addr_err, if1.link_we, if1.link_data}, q1.pop_front());
    end
    always @(negedge clk) if (if2.resolve_valid === 1'b1) begin
        if (q2.size() == 0) check("ds2 unexpected resolve", 1, 0);
        else compare_res("ds2", res_t'{if2.resolve_taken, if2.resolve_pc, if2.resolve_addr_err, if2.link_we, if2.link_data}, q2.pop_front());
    end

    // Called at a negedge; mask bit i pushes the model result for the DELAY_SLOTS=i unit.
    task automatic issue(input logic [3:0] o, input logic [31:0] p, a, b,
                         input logic [25:0] im, input logic [2:0] mask);
        int n = 0;
        while (!(if0.issue_ready && if1.issue_ready && if2.issue_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("issue_ready timeout", 0, 1);
        if (mask[0]) q0.push_back(model(o, p, a, b, im, 0));
        if (mask[1]) q1.push_back(model(o, p, a, b, im, 1));
        if (mask[2]) q2.push_back(model(o, p, a, b, im, 2));
        op = o; pc = p; rs = a; rt = b; imm = im;
        issue_valid = 1'b1;
        @(negedge clk);
        issue_valid = 1'b0;
    endtask

    task automatic commit();
        slot_commit = 1'b1;
        @(negedge clk);
        slot_commit = 1'b0;
    endtask

    task automatic run_commits();
        commit();
        commit();
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " issue_ready"},   64'(if1.issue_ready), 1);
        check({tag, " resolve_valid"}, 64'(if1.resolve_valid), 0);
        check({tag, " resolve_taken"}, 64'(if1.resolve_taken), 0);
        check({tag, " resolve_pc"},    64'(if1.resolve_pc), 0);
        check({tag, " addr_err"},      64'(if1.resolve_addr_err), 0);
        check({tag, " link_we"},       64'(if1.link_we), 0);
        check({tag, " link_data"},     64'(if1.link_data), 0);
        check({tag, " slot_nullify"},  64'(if1.slot_nullify), 0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'd5;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        q1.push_back('{taken: 1'b1, pc: 32'h0040_0014, err: 1'b0, lw: 1'b0, ld: 32'h0040_0008});
        issue(4'd0, 32'h0040_0000, 32'd5, 32'd5, 26'h0004, 3'b101);
        check("ds1 busy after accept", 64'(if1.issue_ready), 0);
        run_commits();

        q2.push_back('{taken: 1'b0, pc: 32'h0040_010C, err: 1'b0, lw: 1'b0, ld: 32'h0040_010C});
        issue(4'd1, 32'h0040_0100, 32'd7, 32'd7, 26'h0010, 3'b011);
        commit();
        repeat (3) begin
            check("ds2 early resolve", 64'(if2.resolve_valid), 0);
            check("ds2 busy in slot", 64'(if2.issue_ready), 0);
            @(negedge clk);
        end
        commit();
        @(negedge clk);

        q1.push_back('{taken: 1'b1, pc: 32'h0040_0102, err: 1'b1, lw: 1'b1, ld: 32'h0040_0208});
        issue(4'd11, 32'h0040_0200, 32'h0040_0102, 32'd0, 26'd0, 3'b101);
        run_commits();

        issue(4'd0, 32'h0040_0300, 32'd3, 32'd3, 26'h0002, 3'b001);
        slot_commit = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        slot_commit = 1'b0;
        flush = 1'b0;
        check("flush ds1 ready", 64'(if1.issue_ready), 1);
        check("flush ds2 ready", 64'(if2.issue_ready), 1);
        repeat (3) begin
            check("flush ds1 no resolve", 64'(if1.resolve_valid), 0);
            check("flush ds2 no resolve", 64'(if2.resolve_valid), 0);
            @(negedge clk);
        end

        issue(4'd12, 32'h0040_0400, 32'd1, 32'd2, 26'h0008, 3'b111);
        check("ds1 nullify not-taken likely", 64'(if1.slot_nullify), 64'(LIKELY));
        commit();
        check("ds2 nullify not-taken likely", 64'(if2.slot_nullify), 64'(LIKELY));
        commit();
        @(negedge clk);
        issue(4'd12, 32'h0040_0500, 32'd9, 32'd9, 26'h0008, 3'b111);
        check("ds1 nullify taken likely", 64'(if1.slot_nullify), 0);
        run_commits();
        issue(4'd0, 32'h0040_0600, 32'd1, 32'd2, 26'h0008, 3'b111);
        check("ds1 nullify plain beq", 64'(if1.slot_nullify), 0);
        run_commits();

        issue(4'd9, 32'hF000_0000, 32'd0, 32'd0, 26'h3FF_FFFF, 3'b111);
        run_commits();
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            a = pick_operand();
            b = ($urandom_range(0, 1) == 0) ? a : pick_operand();
            issue(4'($urandom_range(0, 15)), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, a, b,
                  26'($urandom), 3'b111);
            run_commits();
        end

        issue(4'd9, 32'h0040_0700, 32'd0, 32'd0, 26'h0010_0000, 3'b001);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset mid-slot");
        check("reset mid-slot ds2 ready", 64'(if2.issue_ready), 1);
        reset = 1'b0;
        repeat (3) begin
            check("post-reset ds1 no resolve", 64'(if1.resolve_valid), 0);
            @(negedge clk);
        end

        check("ds0 pending results", 64'(q0.size()), 0);
        check("ds1 pending results", 64'(q1.size()), 0);
        check("ds2 pending results", 64'(q2.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
